riscv_boot_sequencer: RTL and testbench
=======================================

// Module: riscv_boot_sequencer
// PURPOSE
//  Loads a program into the single-cycle core's instruction memory from a streaming source, then runs the core for a bounded cycle count.
//  Sits between the top level and the core. Drives the core reset, instruction-write strobe and instruction word, and a core run-enable.
//  Each load/run session is a 5-state FSM.
// PARAMETERS
//  IMEM_ADDR_W   10    instruction memory address width; capacity 2**IMEM_ADDR_W words
//  INSTR_W       32    instruction word width
//  CYC_W         16    width of run-cycle budget / counter
//  WDOG_LIMIT    255   max idle cycles waiting for s_valid in LOAD (WATCHDOG_EN only)
// PORTS
//  clk           in   1              clock
//  rst           in   1              reset, asynchronous, active-low
//  start         in   1              pulse: begin new session (sampled in IDLE/HALT only)
//  prog_len      in   IMEM_ADDR_W+1  words to load; captured on accepted start
//  run_cycles    in   CYC_W          core cycles to run; 0 = unbounded; captured on start
//  s_valid       in   1              source word valid
//  s_data        in   INSTR_W        source instruction word
//  s_ready       out  1              sequencer accepts word this cycle
//  core_rst_n    out  1              reset to core, active-low
//  ins_write     out  1              core instruction-write strobe
//  instr_out     out  INSTR_W        instruction word to core
//  wr_count      out  IMEM_ADDR_W+1  words written this session
//  core_run      out  1              core clock-enable; high only in RUN
//  busy          out  1              state != IDLE && state != HALT
//  done          out  1              one-cycle pulse on RUN->HALT
//  err           out  1              sticky error flag; cleared on start
// BEHAVIOUR
//  Reset values: core_rst_n=0, ins_write=0, s_ready=0, instr_out=0, wr_count=0, core_run=0, busy=0, done=0, err=0, state=IDLE.
//  States: IDLE, CLEAR, LOAD, RUN, HALT. All outputs are registered except s_ready.
//  IDLE: core_rst_n=0. On start go to CLEAR, latch prog_len/run_cycles, clear wr_count and err.
//  CLEAR: exactly 1 cycle, core_rst_n=0. This zeroes the core's internal write pointer. Then LOAD.
//  LOAD: core_rst_n=1. s_ready = (wr_count < prog_len), combinational.
//   - Handshake: a word transfers when s_valid && s_ready.
//   - On transfer, next cycle: instr_out=s_data, ins_write=1 (one cycle per word), wr_count+1.
//   - ins_write=0 in any cycle with no transfer. Back-to-back transfers give 1 word/cycle.
//   - When wr_count reaches prog_len (after the last strobe), go to RUN.
//   - prog_len=0: LOAD lasts 1 cycle, no strobes.
//   - prog_len > 2**IMEM_ADDR_W: clamp to 2**IMEM_ADDR_W and set err.
//  RUN: core_run=1, ins_write=0. Cycle counter increments each cycle.
//   - When counter == run_cycles (run_cycles!=0), go to HALT and pulse done.
//   - run_cycles=0: stay in RUN until rst.
//  HALT: core_run=0, core_rst_n=1, so core state is held for readout. A start here begins a new session (CLEAR).
//  start outside IDLE/HALT is ignored.
//  An asynchronous rst at any point returns to IDLE. A partially loaded program is discarded; the next session reloads from word 0.
//  Counters never wrap: wr_count saturates at prog_len; the cycle counter stops at run_cycles.
// CONFIGURATION
//  WATCHDOG_EN defined: in LOAD, an idle counter counts cycles with s_ready && !s_valid and clears on each transfer.
//   - Reaching WDOG_LIMIT sets err and goes to HALT with no done pulse.
//  WATCHDOG_EN undefined: no idle counter; LOAD waits indefinitely. err is set only by prog_len clamp.
// STRUCTURE
//  Shared package riscv_ctrl_pkg holds the state enum (IDLE..HALT, 3-bit encoding) and the default widths IMEM_ADDR_W/INSTR_W.
//  The core's opcode constants already live there.
//  One sub-module: boot_cycle_counter (loadable up-counter with terminal-count compare), reused for the RUN budget and the watchdog.
// TESTING
//  Reset mid-LOAD after 3 of 8 words -> IDLE, core_rst_n=0, wr_count=0, no further ins_write.
//  start, prog_len=4, s_valid held high -> 4 consecutive ins_write pulses; instr_out tracks the data; RUN entered on the cycle after the 4th strobe.
//  s_valid toggling 1,0,1,0 -> ins_write only on cycles after a transfer; s_ready drops once wr_count=prog_len.
//  run_cycles=10 -> core_run high exactly 10 cycles; done pulses once; state=HALT; start in HALT restarts via CLEAR.
//  prog_len=0, run_cycles=0 -> no strobes, RUN held indefinitely; start ignored while busy.
//  WATCHDOG_EN, WDOG_LIMIT=16, s_valid low after 2 words -> err=1 and HALT after 16 idle cycles; no done pulse.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control package: boot-sequencer state encoding and default
// instruction-memory / instruction-word widths used across the core.
package riscv_ctrl_pkg;

   localparam int IMEM_ADDR_W = 10;
   localparam int INSTR_W     = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      HALT  = 3'd4
   } boot_state_e;

endpackage

// File: rtl/riscv_boot_sequencer_if.sv
// Streaming program-source bus: valid/ready handshake carrying one
// instruction word per transfer. master = source, slave = sequencer.
interface riscv_boot_sequencer_if #(
   parameter int INSTR_W = riscv_ctrl_pkg::INSTR_W
);
   logic               s_valid;
   logic [INSTR_W-1:0] s_data;
   logic               s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/riscv_boot_sequencer_counter.sv
// boot_cycle_counter: loadable up-counter with terminal-count compare.
// Holds at the limit (or at all-ones) so it never wraps.
module boot_cycle_counter #(
   parameter int CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CYC_W-1:0] load_val,
   input  logic             en,
   input  logic [CYC_W-1:0] limit,
   output logic             tc
);

   logic [CYC_W-1:0] count;

   // Reload on request, otherwise count up until the limit or saturation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != limit) && (count != {CYC_W{1'b1}})) begin
         count <= count + CYC_W'(1);
      end
   end

   assign tc = (count == limit);

endmodule

// File: rtl/riscv_boot_sequencer.sv
// riscv_boot_sequencer: streams a program into the core's instruction
// memory, then runs the core for a bounded number of cycles.
// Optional feature macro: WATCHDOG_EN (LOAD idle watchdog, limit WDOG_LIMIT).
module riscv_boot_sequencer #(
   parameter int IMEM_ADDR_W = riscv_ctrl_pkg::IMEM_ADDR_W,
   parameter int INSTR_W     = riscv_ctrl_pkg::INSTR_W,
   parameter int CYC_W       = 16
`ifdef WATCHDOG_EN
   ,
   parameter int WDOG_LIMIT  = 255
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [IMEM_ADDR_W:0]   prog_len,
   input  logic [CYC_W-1:0]       run_cycles,
   riscv_boot_sequencer_if.slave  src,
   output logic                   core_rst_n,
   output logic                   ins_write,
   output logic [INSTR_W-1:0]     instr_out,
   output logic [IMEM_ADDR_W:0]   wr_count,
   output logic                   core_run,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);
   import riscv_ctrl_pkg::*;

   // Largest program the instruction memory can hold.
   localparam logic [IMEM_ADDR_W:0] MAX_WORDS = {1'b1, {IMEM_ADDR_W{1'b0}}};

   boot_state_e          state_q, state_d;
   logic [IMEM_ADDR_W:0] len_q;
   logic [CYC_W-1:0]     run_q;
   logic                 run_tc;
   logic                 wdog_hit;
   logic                 start_ok;
   logic                 xfer;

   assign start_ok    = start && ((state_q == IDLE) || (state_q == HALT));
   assign src.s_ready = (state_q == LOAD) && (wr_count < len_q) && !wdog_hit;
   assign xfer        = src.s_valid && src.s_ready;

   // Run budget: preset to 1 on entry so the count equals cycles spent in RUN.
   boot_cycle_counter #(.CYC_W(CYC_W)) u_run_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (state_q != RUN),
      .load_val (CYC_W'(1)),
      .en       (state_q == RUN),
      .limit    (run_q),
      .tc       (run_tc)
   );

`ifdef WATCHDOG_EN
   logic wdog_tc;

   // Idle watchdog: counts stalled LOAD cycles, restarts on every transfer.
   boot_cycle_counter #(.CYC_W(CYC_W)) u_wdog_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     ((state_q != LOAD) || xfer),
      .load_val ('0),
      .en       (src.s_ready && !src.s_valid),
      .limit    (CYC_W'(WDOG_LIMIT)),
      .tc       (wdog_tc)
   );

   assign wdog_hit = (state_q == LOAD) && wdog_tc;
`else
   assign wdog_hit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state selection for one load/run session.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   state_d = LOAD;
         LOAD: begin
            if (wdog_hit)               state_d = HALT;
            else if (wr_count == len_q) state_d = RUN;
         end
         RUN:     if ((run_q != '0) && run_tc) state_d = HALT;
         HALT:    if (start) state_d = CLEAR;
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs, session parameters and the write counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_rst_n <= 1'b0;
         core_run   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         ins_write  <= 1'b0;
         instr_out  <= '0;
         wr_count   <= '0;
         err        <= 1'b0;
         len_q      <= '0;
         run_q      <= '0;
      end else begin
         core_rst_n <= (state_d != IDLE) && (state_d != CLEAR);
         core_run   <= (state_d == RUN);
         busy       <= (state_d == CLEAR) || (state_d == LOAD) || (state_d == RUN);
         done       <= (state_q == RUN) && (state_d == HALT);
         ins_write  <= xfer;
         if (xfer) begin
            instr_out <= src.s_data;
            wr_count  <= wr_count + 1'b1;
         end
         if (start_ok) begin
            wr_count <= '0;
            run_q    <= run_cycles;
            len_q    <= (prog_len > MAX_WORDS) ? MAX_WORDS : prog_len;
            err      <= (prog_len > MAX_WORDS);
         end else if (wdog_hit) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_riscv_boot_sequencer.sv
// Bench for riscv_boot_sequencer: randomized load/run sessions compared
// against a transaction-level expectation of strobes, data and run length.
module tb_riscv_boot_sequencer;

   localparam int AW = 10;
   localparam int IW = 32;
   localparam int CW = 16;
`ifdef WATCHDOG_EN
   localparam int WDOG = 16;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   prog_len = '0;
   logic [CW-1:0] run_cycles = '0;
   logic          core_rst_n, ins_write, core_run, busy, done, err;
   logic [IW-1:0] instr_out;
   logic [AW:0]   wr_count;

   int n_checks = 0;
   int n_errors = 0;

   riscv_boot_sequencer_if #(.INSTR_W(IW)) src_if ();

   riscv_boot_sequencer #(
      .IMEM_ADDR_W (AW),
      .INSTR_W     (IW),
      .CYC_W       (CW)
`ifdef WATCHDOG_EN
      ,
      .WDOG_LIMIT  (WDOG)
`endif
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prog_len   (prog_len),
      .run_cycles (run_cycles),
      .src        (src_if.slave),
      .core_rst_n (core_rst_n),
      .ins_write  (ins_write),
      .instr_out  (instr_out),
      .wr_count   (wr_count),
      .core_run   (core_run),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_core_rst_n", core_rst_n, 0);
      check_eq("rst_ins_write", ins_write, 0);
      check_eq("rst_instr_out", instr_out, 0);
      check_eq("rst_wr_count", wr_count, 0);
      check_eq("rst_core_run", core_run, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_s_ready", src_if.s_ready, 0);
   endtask

   // Called just after a falling edge; asserts reset asynchronously mid-cycle.
   task automatic apply_reset();
      #2 rst = 1'b0;
      #1 check_reset_outputs();
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   // Start a session and walk it through CLEAR, LOAD and RUN.
   // vmode: 0 = s_valid held high, 1 = toggling 1,0,1,0, 2 = random.
   task automatic run_session(input int len, input int runc, input int vmode);
      int            eff_len, accepted, guard, n_run;
      bit            pend, load_done, tgl, v, exp_err;
      logic [IW-1:0] pend_data;
      eff_len = (len > (1 << AW)) ? (1 << AW) : len;
      exp_err = (len > (1 << AW));
      @(negedge clk);
      start = 1'b1;
      prog_len = (AW+1)'(len);
      run_cycles = CW'(runc);
      src_if.s_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      prog_len = (AW+1)'($urandom);
      run_cycles = CW'($urandom);
      check_eq("clear_core_rst_n", core_rst_n, 0);
      check_eq("clear_busy", busy, 1);
      check_eq("clear_wr_count", wr_count, 0);
      check_eq("clear_err", err, exp_err);
      pend = 1'b0; accepted = 0; load_done = 1'b0; guard = 0; tgl = 1'b1; pend_data = '0;
      while (!load_done) begin
         @(negedge clk);
         guard++;
         check_eq("load_ins_write", ins_write, pend);
         if (pend) check_eq("load_instr_out", instr_out, pend_data);
         check_eq("load_wr_count", wr_count, accepted);
         check_eq("load_s_ready", src_if.s_ready, accepted < eff_len);
         check_eq("load_core_run", core_run, 0);
         check_eq("load_core_rst_n", core_rst_n, 1);
         if (accepted == eff_len || guard > 4 * eff_len + 20) begin
            if (accepted != eff_len) check_eq("load_timeout", accepted, eff_len);
            load_done = 1'b1;
            src_if.s_valid = 1'b0;
         end else begin
            case (vmode)
               0:       v = 1'b1;
               1:       begin v = tgl; tgl = !tgl; end
               default: v = ($urandom_range(0, 3) != 0);
            endcase
            src_if.s_valid = v;
            src_if.s_data = $urandom;
            pend = v;
            if (v) begin
               accepted++;
               pend_data = src_if.s_data;
            end
         end
      end
      @(negedge clk);
      check_eq("run_entry_core_run", core_run, 1);
      check_eq("run_entry_ins_write", ins_write, 0);
      check_eq("run_entry_busy", busy, 1);
      if (runc != 0) begin
         n_run = 0;
         while (core_run === 1'b1 && n_run <= runc + 4) begin
            n_run++;
            check_eq("run_done_low", done, 0);
            @(negedge clk);
         end
         check_eq("run_length", n_run, runc);
         check_eq("halt_done_pulse", done, 1);
         check_eq("halt_busy", busy, 0);
         check_eq("halt_core_rst_n", core_rst_n, 1);
         check_eq("halt_err", err, exp_err);
         @(negedge clk);
         check_eq("halt_done_single", done, 0);
         check_eq("halt_core_run", core_run, 0);
      end else begin
         for (int i = 0; i < 30; i++) begin
            start = (i == 10);
            prog_len = (AW+1)'(5);
            @(negedge clk);
            check_eq("unbounded_core_run", core_run, 1);
            check_eq("unbounded_busy", busy, 1);
         end
         start = 1'b0;
         check_eq("unbounded_wr_hold", wr_count, eff_len);
         check_eq("unbounded_done", done, 0);
         apply_reset();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int seen_idle;
      bit seen_done;
      src_if.s_valid = 1'b0;
      src_if.s_data = '0;
      #12;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b1;

      run_session(4, 10, 0);
      run_session(6, 3, 1);

      // Reset in the middle of loading an 8-word program after 3 words.
      @(negedge clk);
      start = 1'b1; prog_len = (AW+1)'(8); run_cycles = CW'(5);
      @(negedge clk);
      start = 1'b0;
      src_if.s_valid = 1'b1;
      src_if.s_data = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check_eq("midload_wr_count", wr_count, 2);
      @(negedge clk);
      check_eq("midload_wr_count3", wr_count, 3);
      #2 rst = 1'b0;
      #1;
      check_eq("midload_core_rst_n", core_rst_n, 0);
      check_eq("midload_wr_zero", wr_count, 0);
      check_eq("midload_busy", busy, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("midload_no_strobe", ins_write, 0);
         check_eq("midload_no_ready", src_if.s_ready, 0);
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("idle_no_strobe", ins_write, 0);
         check_eq("idle_core_rst_n", core_rst_n, 0);
      end
      src_if.s_valid = 1'b0;
      run_session(8, 4, 0);

      for (int s = 0; s < 6; s++)
         run_session($urandom_range(0, 20), $urandom_range(1, 25), $urandom_range(0, 2));

      run_session(1030, 2, 0);
      run_session(3, 1, 2);

      // Source stalls after two words.
      @(negedge clk);
      start = 1'b1; prog_len = (AW+1)'(8); run_cycles = CW'(5);
      @(negedge clk);
      start = 1'b0;
      src_if.s_valid = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("stall_wr_count", wr_count, 2);
      src_if.s_valid = 1'b0;
`ifdef WATCHDOG_EN
      seen_idle = 0; seen_done = 1'b0;
      for (int g = 0; g < 100 && busy === 1'b1; g++) begin
         if (src_if.s_ready === 1'b1) seen_idle++;
         if (done === 1'b1) seen_done = 1'b1;
         @(negedge clk);
      end
      check_eq("wdog_idle_cycles", seen_idle, WDOG);
      check_eq("wdog_err", err, 1);
      check_eq("wdog_busy", busy, 0);
      check_eq("wdog_core_run", core_run, 0);
      check_eq("wdog_no_done", seen_done | done, 0);
      run_session(3, 2, 0);
`else
      seen_idle = 0; seen_done = 1'b0;
      for (int g = 0; g < 300; g++) begin
         if (src_if.s_ready === 1'b1) seen_idle++;
         if (done === 1'b1) seen_done = 1'b1;
         @(negedge clk);
      end
      check_eq("stall_idle_cycles", seen_idle, 300);
      check_eq("stall_busy", busy, 1);
      check_eq("stall_err", err, 0);
      check_eq("stall_no_done", seen_done, 0);
      apply_reset();
`endif

      run_session(0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
